// File: rtl/i8080_pkg.sv
// Shared 8080 bus definitions: machine-cycle state encoding and status-byte bit positions.
package i8080_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4,
        ST_HOLD = 3'd5
    } bus_state_t;

    localparam int STATUS_INTA  = 0;
    localparam int STATUS_WO_N  = 1;
    localparam int STATUS_STACK = 2;
    localparam int STATUS_HLTA  = 3;
    localparam int STATUS_OUT   = 4;
    localparam int STATUS_M1    = 5;
    localparam int STATUS_INP   = 6;
    localparam int STATUS_MEMR  = 7;

    // A cleared WO_n bit in the status byte marks a write machine cycle.
    function automatic logic is_write_cycle(input logic [7:0] status);
        return ~status[STATUS_WO_N];
    endfunction

endpackage

// File: rtl/bus_sequencer.sv
// 8080-style machine-cycle sequencer (T1/T2/TW/T3) driving a split external data bus.
// Optional bus hold/acknowledge support is enabled by defining BUS_HOLD_EN.
module bus_sequencer
    import i8080_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_status,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] addr,
    output logic        addr_oe,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in,
    output logic        sync,
    output logic        dbin,
    output logic        write_n,
    output logic        wwait,
    input  logic        ready,
    input  logic        hold,
    output logic        hlda
);

    bus_state_t  state;
    logic [7:0]  status_q;
    logic [7:0]  wdata_q;
    logic        hold_req;
    logic        wr_cycle;

`ifdef BUS_HOLD_EN
    assign hold_req = hold;
    assign hlda     = (state == ST_HOLD);
`else
    logic unused_hold;
    assign unused_hold = hold;
    assign hold_req    = 1'b0;
    assign hlda        = 1'b0;
`endif

    assign wr_cycle  = is_write_cycle(status_q);
    assign req_ready = (state == ST_IDLE) && !hold_req;
    assign addr_oe   = (state != ST_HOLD);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            status_q  <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hold_req) begin
                        state <= ST_HOLD;
                    end else if (req_valid) begin
                        addr     <= req_addr;
                        status_q <= req_status;
                        wdata_q  <= req_wdata;
                        state    <= ST_T1;
                    end
                end
                ST_T1:        state <= ST_T2;
                ST_T2, ST_TW: state <= ready ? ST_T3 : ST_TW;
                ST_T3: begin
                    rsp_valid <= 1'b1;
                    if (!wr_cycle) rsp_rdata <= data_in;
                    state <= hold_req ? ST_HOLD : ST_IDLE;
                end
                ST_HOLD: if (!hold_req) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every strobe gets its inactive default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        sync     = 1'b0;
        dbin     = 1'b0;
        write_n  = 1'b1;
        wwait    = 1'b0;
        data_oe  = 1'b0;
        data_out = '0;
        case (state)
            ST_T1: begin
                sync     = 1'b1;
                data_oe  = 1'b1;
                data_out = status_q;
            end
            ST_T2, ST_TW, ST_T3: begin
                wwait = (state == ST_TW);
                if (wr_cycle) begin
                    data_oe  = 1'b1;
                    data_out = wdata_q;
                    write_n  = (state != ST_T3);
                end else begin
                    dbin = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: directed cases plus randomized machine cycles
// checked against a cycle-count/phase model. Hold tests run when BUS_HOLD_EN is defined.
module tb_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_status;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [15:0] addr;
    logic        addr_oe;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  data_in;
    logic        sync;
    logic        dbin;
    logic        write_n;
    logic        wwait;
    logic        ready;
    logic        hold;
    logic        hlda;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cycle    = 0;
    logic [7:0]  exp_rdata;

    bus_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_status(req_status),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .addr      (addr),
        .addr_oe   (addr_oe),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .data_in   (data_in),
        .sync      (sync),
        .dbin      (dbin),
        .write_n   (write_n),
        .wwait     (wwait),
        .ready     (ready),
        .hold      (hold),
        .hlda      (hlda)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One machine cycle as seen from the pins: accept at N, T1 at N+1, T2 at N+2,
    // 'waits' TW cycles, T3, then the rsp_valid cycle. Leaves the bench in that last cycle.
    task automatic txn(input logic [15:0] a, input logic [7:0] st, input logic [7:0] wd,
                       input int waits, input logic [7:0] din, input bit hold_t2);
        bit rd;
        int t0;
        rd = st[1];
        check("accept_ready", 32'(req_ready), 1);
        req_valid  = 1'b1;
        req_addr   = a;
        req_status = st;
        req_wdata  = wd;
        ready      = 1'($urandom);
        t0         = cycle;
        step();
        req_valid  = 1'b0;
        req_addr   = 16'($urandom);
        req_status = 8'($urandom);
        req_wdata  = 8'($urandom);

        check("t1_sync",      32'(sync),      1);
        check("t1_data_oe",   32'(data_oe),   1);
        check("t1_data_out",  32'(data_out),  32'(st));
        check("t1_addr",      32'(addr),      32'(a));
        check("t1_dbin",      32'(dbin),      0);
        check("t1_rsp_valid", 32'(rsp_valid), 0);
        check("t1_req_ready", 32'(req_ready), 0);
        step();

        for (int k = 0; k <= waits; k++) begin
            check("t2_wwait",     32'(wwait),     32'(k > 0));
            check("t2_dbin",      32'(dbin),      32'(rd));
            check("t2_data_oe",   32'(data_oe),   32'(!rd));
            if (!rd) check("t2_data_out", 32'(data_out), 32'(wd));
            check("t2_write_n",   32'(write_n),   1);
            check("t2_sync",      32'(sync),      0);
            check("t2_addr_oe",   32'(addr_oe),   1);
            check("t2_rsp_valid", 32'(rsp_valid), 0);
            if (k == 0 && hold_t2) hold = 1'b1;
            ready = (k == waits);
            step();
        end

        check("t3_dbin",      32'(dbin),      32'(rd));
        check("t3_write_n",   32'(write_n),   32'(rd));
        check("t3_data_oe",   32'(data_oe),   32'(!rd));
        if (!rd) check("t3_data_out", 32'(data_out), 32'(wd));
        check("t3_wwait",     32'(wwait),     0);
        check("t3_rsp_valid", 32'(rsp_valid), 0);
        data_in = din;
        ready   = 1'($urandom);
        step();
        data_in = 8'($urandom);
        if (rd) exp_rdata = din;

        check("done_rsp_valid", 32'(rsp_valid), 1);
        check("done_latency",   32'(cycle - t0), 32'(4 + waits));
        check("done_rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
        check("done_write_n",   32'(write_n),   1);
        check("done_dbin",      32'(dbin),      0);
        check("done_data_oe",   32'(data_oe),   0);
        check("done_addr",      32'(addr),      32'(a));
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_status = '0;
        req_wdata  = '0;
        data_in    = '0;
        ready      = 1'b1;
        hold       = 1'b0;
        exp_rdata  = '0;
        step();
        step();

        check("rst_addr",      32'(addr),      0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        check("rst_hlda",      32'(hlda),      0);
        check("rst_write_n",   32'(write_n),   1);
        check("rst_strobes",   32'({sync, dbin, wwait, data_oe}), 0);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_addr_oe",   32'(addr_oe),   1);
        rst = 1'b0;
        step();

        // Basic read, then confirm rsp_valid is a single pulse.
        txn(16'h2000, 8'hA2, 8'h00, 0, 8'h5A, 1'b0);
        step();
        check("read_pulse_end", 32'(rsp_valid), 0);

        // Write: rsp_rdata must keep the earlier read data.
        txn(16'h1234, 8'h00, 8'hC3, 0, 8'($urandom), 1'b0);
        step();

        // Read stretched by three wait states.
        txn(16'h4000, 8'h82, 8'h00, 3, 8'h77, 1'b0);
        step();

        // Back-to-back: second request accepted in the first one's rsp_valid cycle.
        txn(16'h0101, 8'hA2, 8'h00, 0, 8'h3C, 1'b0);
        txn(16'h0202, 8'h00, 8'h99, 1, 8'hEE, 1'b0);
        step();
        check("b2b_idle_after", 32'(rsp_valid), 0);

`ifdef BUS_HOLD_EN
        // Hold raised in T2: cycle completes, then HOLD.
        txn(16'h3000, 8'hA2, 8'h00, 1, 8'h11, 1'b1);
        check("hold_hlda",      32'(hlda),      1);
        check("hold_addr_oe",   32'(addr_oe),   0);
        check("hold_data_oe",   32'(data_oe),   0);
        check("hold_req_ready", 32'(req_ready), 0);
        req_valid = 1'b1;
        step();
        check("hold_stays",     32'(hlda),      1);
        check("hold_no_sync",   32'(sync),      0);
        req_valid = 1'b0;
        hold      = 1'b0;
        step();
        check("unhold_hlda",      32'(hlda),      0);
        check("unhold_req_ready", 32'(req_ready), 1);
        check("unhold_addr_oe",   32'(addr_oe),   1);
        // Hold in IDLE takes priority over a simultaneous request.
        hold      = 1'b1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("hold_prio_hlda", 32'(hlda), 1);
        check("hold_prio_sync", 32'(sync), 0);
        hold = 1'b0;
        step();
        check("hold_prio_idle", 32'(req_ready), 1);
        check("hold_prio_t1",   32'(sync),      0);
`else
        // Without hold support the hold input has no effect.
        hold = 1'b1;
        #1;
        check("nohold_req_ready", 32'(req_ready), 1);
        check("nohold_hlda",      32'(hlda),      0);
        txn(16'h3000, 8'hA2, 8'h00, 0, 8'h11, 1'b0);
        check("nohold_hlda_end",  32'(hlda),      0);
        check("nohold_addr_oe",   32'(addr_oe),   1);
        hold = 1'b0;
        step();
`endif

        // Reset during a wait state aborts the write cycle.
        check("abort_accept", 32'(req_ready), 1);
        req_valid  = 1'b1;
        req_addr   = 16'h5555;
        req_status = 8'h00;
        req_wdata  = 8'h99;
        step();
        req_valid = 1'b0;
        ready     = 1'b0;
        step();
        step();
        check("abort_in_tw", 32'(wwait), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_rdata = '0;
        check("abort_write_n",   32'(write_n),   1);
        check("abort_strobes",   32'({sync, dbin, wwait, data_oe}), 0);
        check("abort_rsp_valid", 32'(rsp_valid), 0);
        check("abort_addr",      32'(addr),      0);
        check("abort_rsp_rdata", 32'(rsp_rdata), 0);
        check("abort_req_ready", 32'(req_ready), 1);
        ready = 1'b1;
        step();
        check("abort_no_rsp", 32'(rsp_valid), 0);

        // Randomized machine cycles, sometimes back-to-back.
        for (int i = 0; i < 24; i++) begin
            txn(16'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                8'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 0) begin
                step();
                check("rand_gap_no_rsp", 32'(rsp_valid), 0);
            end
        end
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
